// File: rtl/conv_pre_ctrl.sv
// Layer sequencer for the convolution pre-processor: latches geometry/mode, programs the
// line buffer, gates the pixel stream and tags which pre-processor outputs are real windows.
module conv_pre_ctrl #(
   parameter int DIM_WIDTH = 9,
   parameter int PIPE_LAT  = 2,
   parameter int KERNEL    = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [DIM_WIDTH-1:0] cfg_width,
   input  logic [DIM_WIDTH-1:0] cfg_height,
   input  logic                 cfg_pw_mode,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic                 pp_valid_in,
   output logic [DIM_WIDTH-1:0] pp_buff_len_ctrl,
   output logic                 pp_buff_len_rst,
   output logic                 pp_pw_mode,
   output logic                 win_valid,
   output logic                 win_last,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [DIM_WIDTH-1:0] ONE    = DIM_WIDTH'(1);
   localparam logic [DIM_WIDTH-1:0] K_MIN  = DIM_WIDTH'(KERNEL);
   localparam logic [DIM_WIDTH-1:0] K_EDGE = DIM_WIDTH'(KERNEL - 1);
   localparam int                   DRN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRN_W-1:0]     DRN_END = DRN_W'(PIPE_LAT - 1);

   state_t               state;
   logic [DIM_WIDTH-1:0] width_q;
   logic [DIM_WIDTH-1:0] height_q;
   logic [DIM_WIDTH-1:0] row;
   logic [DIM_WIDTH-1:0] col;
   logic [DRN_W-1:0]     drain_cnt;
   logic [PIPE_LAT-1:0]  tag_sr;
   logic [PIPE_LAT-1:0]  last_sr;
   logic                 cfg_bad;
   logic                 beat;
   logic                 final_beat;
   logic                 tag;

   // Handshake: a beat transfers in any cycle where src_valid and src_ready are both high;
   // the same beat is forwarded to the pre-processor in that cycle with no added latency.
   assign beat        = src_valid & src_ready;
   assign pp_valid_in = beat;

   assign cfg_bad    = (cfg_width == '0) || (cfg_height == '0) ||
                       (!cfg_pw_mode && ((cfg_width < K_MIN) || (cfg_height < K_MIN)));
   assign final_beat = (row == height_q - ONE) && (col == width_q - ONE);
   assign tag        = pp_pw_mode || ((row >= K_EDGE) && (col >= K_EDGE));

   assign win_valid = tag_sr[PIPE_LAT-1];
   assign win_last  = last_sr[PIPE_LAT-1];

   // Tag pipeline mirrors the pre-processor latency; idle cycles shift in zeros.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag_sr  <= '0;
         last_sr <= '0;
      end else begin
         tag_sr  <= (tag_sr << 1)  | PIPE_LAT'(beat & tag);
         last_sr <= (last_sr << 1) | PIPE_LAT'(beat & tag & final_beat);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= S_IDLE;
         width_q          <= '0;
         height_q         <= '0;
         row              <= '0;
         col              <= '0;
         drain_cnt        <= '0;
         src_ready        <= 1'b0;
         pp_buff_len_ctrl <= '0;
         pp_buff_len_rst  <= 1'b0;
         pp_pw_mode       <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         cfg_err          <= 1'b0;
      end else begin
         pp_buff_len_rst <= 1'b0;
         done            <= 1'b0;
         cfg_err         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  width_q  <= cfg_width;
                  height_q <= cfg_height;
                  busy     <= 1'b1;
                  if (cfg_bad) begin
                     // Error path skips CFG so the pre-processor keeps its previous setup.
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                     state   <= S_DONE;
                  end else begin
                     pp_buff_len_rst  <= 1'b1;
                     pp_buff_len_ctrl <= cfg_pw_mode ? '0 : cfg_width - DIM_WIDTH'(2);
                     pp_pw_mode       <= cfg_pw_mode;
                     state            <= S_CFG;
                  end
               end
            end
            S_CFG: begin
               row       <= '0;
               col       <= '0;
               src_ready <= 1'b1;
               state     <= S_RUN;
            end
            S_RUN: begin
               if (beat) begin
                  if (final_beat) begin
                     src_ready <= 1'b0;
                     drain_cnt <= '0;
                     state     <= S_DRAIN;
                  end else if (col == width_q - ONE) begin
                     col <= '0;
                     row <= row + ONE;
                  end else begin
                     col <= col + ONE;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRN_END) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_pre_ctrl.sv
// Directed bench for conv_pre_ctrl: per-cycle stream model with an expected-tag queue
// aligned to the pre-processor latency.
module tb_conv_pre_ctrl;

   localparam int DIM_WIDTH = 9;
   localparam int PIPE_LAT  = 2;
   localparam int KERNEL    = 3;

   logic                 clk;
   logic                 rstn;
   logic                 start;
   logic [DIM_WIDTH-1:0] cfg_width;
   logic [DIM_WIDTH-1:0] cfg_height;
   logic                 cfg_pw_mode;
   logic                 src_valid;
   logic                 src_ready;
   logic                 pp_valid_in;
   logic [DIM_WIDTH-1:0] pp_buff_len_ctrl;
   logic                 pp_buff_len_rst;
   logic                 pp_pw_mode;
   logic                 win_valid;
   logic                 win_last;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;

   conv_pre_ctrl #(.DIM_WIDTH(DIM_WIDTH), .PIPE_LAT(PIPE_LAT), .KERNEL(KERNEL)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .cfg_width        (cfg_width),
      .cfg_height       (cfg_height),
      .cfg_pw_mode      (cfg_pw_mode),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .pp_valid_in      (pp_valid_in),
      .pp_buff_len_ctrl (pp_buff_len_ctrl),
      .pp_buff_len_rst  (pp_buff_len_rst),
      .pp_pw_mode       (pp_pw_mode),
      .win_valid        (win_valid),
      .win_last         (win_last),
      .busy             (busy),
      .done             (done),
      .cfg_err          (cfg_err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state: {last, valid} per cycle, popped PIPE_LAT cycles later
   logic [1:0]           exp_q[$];
   int                   n_chk  = 0;
   int                   n_pass = 0;
   int                   n_fail = 0;
   int                   m_w, m_h, m_row, m_col, m_beats;
   int                   win_cnt, last_cnt;
   logic                 m_pw;
   logic                 exp_ready;
   logic [DIM_WIDTH-1:0] last_ctrl;
   logic                 last_pw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive at posedge+1, check at negedge
   task automatic cycle(input logic v, input logic s, input logic r);
      logic [1:0] t;
      logic [1:0] e;
      logic       acc;
      logic       fin;
      logic       tg;
      @(posedge clk);
      #1;
      src_valid = v;
      start     = s;
      rstn      = r;
      if (!r) begin
         exp_q.delete();
         repeat (PIPE_LAT) exp_q.push_back(2'b00);
         exp_ready = 1'b0;
      end
      @(negedge clk);
      if (!r)
         chk("reset_outputs",
             32'({busy, done, cfg_err, pp_buff_len_rst, pp_pw_mode, pp_buff_len_ctrl}), 32'(0));
      acc = v & exp_ready;
      chk("src_ready", 32'(src_ready), 32'(exp_ready));
      chk("pp_valid_in", 32'(pp_valid_in), 32'(acc));
      t = 2'b00;
      if (acc) begin
         fin = (m_row == m_h - 1) && (m_col == m_w - 1);
         tg  = m_pw || ((m_row >= KERNEL - 1) && (m_col >= KERNEL - 1));
         t   = {tg & fin, tg};
         m_beats++;
         if (fin) exp_ready = 1'b0;
         if (m_col == m_w - 1) begin
            m_col = 0;
            m_row++;
         end else begin
            m_col++;
         end
      end
      exp_q.push_back(t);
      if (exp_q.size() > PIPE_LAT) begin
         e = exp_q.pop_front();
         chk("win_valid", 32'(win_valid), 32'(e[0]));
         chk("win_last", 32'(win_last), 32'(e[1]));
         if (win_valid === 1'b1) win_cnt++;
         if (win_last === 1'b1) last_cnt++;
      end
   endtask

   task automatic run_layer(input int w, input int h, input logic pw, input logic alt,
                            input logic mid_start, input int rst_row);
      int                   k;
      logic                 legal;
      logic [DIM_WIDTH-1:0] e_ctrl;
      cfg_width   = DIM_WIDTH'(w);
      cfg_height  = DIM_WIDTH'(h);
      cfg_pw_mode = pw;
      legal    = (w != 0) && (h != 0) && (pw || ((w >= KERNEL) && (h >= KERNEL)));
      win_cnt  = 0;
      last_cnt = 0;
      cycle(1'b0, 1'b1, 1'b1);
      chk("busy_at_start", 32'(busy), 32'(0));
      if (!legal) begin
         cycle(1'b0, 1'b0, 1'b1);
         chk("err_done", 32'(done), 32'(1));
         chk("err_flag", 32'(cfg_err), 32'(1));
         chk("err_busy", 32'(busy), 32'(1));
         chk("err_no_cfg", 32'(pp_buff_len_rst), 32'(0));
         chk("err_ctrl_hold", 32'(pp_buff_len_ctrl), 32'(last_ctrl));
         chk("err_mode_hold", 32'(pp_pw_mode), 32'(last_pw));
         cycle(1'b0, 1'b0, 1'b1);
         chk("err_done_clr", 32'(done), 32'(0));
         chk("err_flag_clr", 32'(cfg_err), 32'(0));
         chk("err_busy_clr", 32'(busy), 32'(0));
         return;
      end
      e_ctrl = pw ? '0 : DIM_WIDTH'(w - 2);
      cycle(1'b0, 1'b0, 1'b1);
      chk("cfg_len_rst", 32'(pp_buff_len_rst), 32'(1));
      chk("cfg_len_ctrl", 32'(pp_buff_len_ctrl), 32'(e_ctrl));
      chk("cfg_pw_mode", 32'(pp_pw_mode), 32'(pw));
      chk("cfg_busy", 32'(busy), 32'(1));
      last_ctrl = e_ctrl;
      last_pw   = pw;
      m_w = w; m_h = h; m_pw = pw; m_row = 0; m_col = 0; m_beats = 0;
      exp_ready = 1'b1;
      k = 0;
      while (m_beats < w * h && k < 8 * w * h + 8) begin
         if (rst_row != 0 && m_row == rst_row) begin
            cycle(1'b1, 1'b0, 1'b0);
            last_ctrl = '0;
            last_pw   = 1'b0;
            return;
         end
         if (mid_start && k == 5) begin
            cfg_width   = DIM_WIDTH'(9);
            cfg_height  = DIM_WIDTH'(9);
            cfg_pw_mode = ~pw;
            cycle(1'b1, 1'b1, 1'b1);
         end else begin
            cycle(alt ? ~k[0] : 1'b1, 1'b0, 1'b1);
         end
         chk("run_no_done", 32'(done), 32'(0));
         chk("run_ctrl_hold", 32'(pp_buff_len_ctrl), 32'(e_ctrl));
         chk("run_mode_hold", 32'(pp_pw_mode), 32'(pw));
         k++;
      end
      chk("beats_in_budget", 32'(m_beats), 32'(w * h));
      cycle(1'b0, 1'b0, 1'b1);
      chk("drain1_done", 32'(done), 32'(0));
      chk("drain1_busy", 32'(busy), 32'(1));
      cycle(1'b0, 1'b0, 1'b1);
      chk("drain2_done", 32'(done), 32'(0));
      cycle(1'b0, 1'b0, 1'b1);
      chk("done_pulse", 32'(done), 32'(1));
      chk("done_no_err", 32'(cfg_err), 32'(0));
      chk("done_busy", 32'(busy), 32'(1));
      chk("done_ctrl_hold", 32'(pp_buff_len_ctrl), 32'(e_ctrl));
      cycle(1'b0, 1'b0, 1'b1);
      chk("done_clr", 32'(done), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("win_count", 32'(win_cnt), 32'(pw ? w * h : (w - 2) * (h - 2)));
      chk("last_count", 32'(last_cnt), 32'(1));
   endtask

   initial begin
      rstn        = 1'b1;
      start       = 1'b0;
      src_valid   = 1'b0;
      cfg_width   = '0;
      cfg_height  = '0;
      cfg_pw_mode = 1'b0;
      exp_ready   = 1'b0;
      last_ctrl   = '0;
      last_pw     = 1'b0;
      m_w = 1; m_h = 1; m_pw = 1'b0; m_row = 0; m_col = 0; m_beats = 0;
      win_cnt = 0; last_cnt = 0;

      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b1);

      run_layer(5, 4, 1'b0, 1'b0, 1'b0, 0);   // DW, stream held valid
      run_layer(4, 2, 1'b1, 1'b0, 1'b0, 0);   // PW
      run_layer(5, 4, 1'b0, 1'b1, 1'b0, 0);   // DW, gapped stream
      run_layer(5, 4, 1'b0, 1'b0, 1'b0, 0);   // restores ctrl=3 / DW before error layers
      run_layer(2, 4, 1'b0, 1'b0, 1'b0, 0);   // DW too narrow
      run_layer(0, 3, 1'b1, 1'b0, 1'b0, 0);   // PW zero width
      run_layer(5, 4, 1'b0, 1'b0, 1'b1, 0);   // stray start mid-run
      run_layer(6, 3, 1'b0, 1'b0, 1'b0, 0);   // fresh config after done
      run_layer(5, 4, 1'b0, 1'b0, 1'b0, 2);   // reset at row 2
      repeat (4) begin
         cycle(1'b0, 1'b0, 1'b1);
         chk("post_rst_no_done", 32'(done), 32'(0));
         chk("post_rst_idle", 32'(busy), 32'(0));
      end
      run_layer(4, 4, 1'b0, 1'b0, 1'b0, 0);   // clean layer after reset

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_pre_ctrl.md
Name: conv_pre_ctrl

Overview:
Sequencer for the convolution pre-processing stage (line buffer/window generator plus point-wise broadcast path). Per layer it latches geometry and mode, then loads and resets the line-buffer length and selects PW/DW mode. It gates the incoming pixel stream into the pre-processor with a valid/ready handshake and tracks row/column position. It tags which pre-processor outputs are legitimate windows and reports layer completion.

Parameters:
DIM_WIDTH, 9, width of width/height config fields and of pp_buff_len_ctrl (max line 511)
PIPE_LAT, 2, cycles from pp_valid_in to the matching pre-processor output (window register + alignment register)
KERNEL, 3, DW kernel size; a window is valid once row>=KERNEL-1 and col>=KERNEL-1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle layer start; sampled only in IDLE
cfg_width  in  DIM_WIDTH  pixels per row, sampled with start
cfg_height  in  DIM_WIDTH  rows per frame, sampled with start
cfg_pw_mode  in  1  1 = point-wise, 0 = depth-wise 3x3; sampled with start
src_valid  in  1  upstream pixel beat valid
src_ready  out  1  controller accepts a beat
pp_valid_in  out  1  valid_in to the pre-processor
pp_buff_len_ctrl  out  DIM_WIDTH  line-buffer length to the pre-processor
pp_buff_len_rst  out  1  line-buffer length reset/load strobe
pp_pw_mode  out  1  PW/DW select to the pre-processor
win_valid  out  1  current pre-processor output is a legitimate window/pixel
win_last  out  1  last legitimate output of the layer, coincident with win_valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle layer-complete pulse
cfg_err  out  1  one-cycle pulse, coincident with done, on illegal config

Behaviour:
- Reset (rstn low, async): state IDLE; all outputs 0, including pp_buff_len_ctrl and pp_pw_mode. Row/col counters and the tag shift register are cleared. Reset mid-layer abandons the layer: no done pulse, and in-flight tags are discarded.
- States: IDLE -> CFG -> RUN -> DRAIN -> DONE -> IDLE. The ERR path goes IDLE -> DONE.
- IDLE: on start, latch cfg_*.
  - If the config is illegal (width==0, height==0, or DW with width<KERNEL or height<KERNEL): go to DONE with the error flag set.
  - Otherwise go to CFG.
  - start outside IDLE is ignored.
- CFG (1 cycle):
  - pp_buff_len_rst=1.
  - pp_buff_len_ctrl <= width-2 in DW mode, 0 in PW mode. It is registered and held until the next CFG.
  - pp_pw_mode <= latched mode, also held.
- RUN:
  - src_ready=1; pp_valid_in = src_valid & src_ready. This path is combinational with no added latency.
  - Each accepted beat advances col, wrapping at width-1 to 0 and incrementing row.
  - After the beat at row==height-1, col==width-1, go to DRAIN. src_ready drops in the following cycle.
  - Gaps in src_valid stall the counters; there is no timeout.
- Tag per accepted beat:
  - DW: tag = (row>=KERNEL-1) & (col>=KERNEL-1).
  - PW: tag = 1.
  - last = tag & final beat.
  - Tags enter a PIPE_LAT-deep shift register clocked every cycle. Entries are 0 when no beat is accepted.
  - win_valid/win_last are the shift-register outputs, so they follow pp_valid_in by exactly PIPE_LAT cycles.
- DRAIN: src_ready=0; count PIPE_LAT cycles so the final tag emerges, then go to DONE.
- DONE (1 cycle): done=1; cfg_err=1 if on the error path; then go to IDLE. On the error path, pp_* outputs keep their previous values.
- busy = (state != IDLE).
- Counters are DIM_WIDTH bits. width-2 must not underflow because DW requires width>=3. In PW, width=1 is legal.
- Expected win_valid count per layer: DW (width-2)*(height-2); PW width*height.

Test Plan:
- DW, width=5, height=4, src_valid held high -> CFG shows buff_len_rst=1 with pp_buff_len_ctrl=3. Exactly 20 pp_valid_in. 6 win_valid, the first PIPE_LAT=2 cycles after beat 12 (row2,col2). win_last on the 6th. done 2 cycles after the final beat plus the DONE state.
- PW, width=4, height=2 -> pp_pw_mode=1, pp_buff_len_ctrl=0, 8 win_valid each 2 cycles after its beat, win_last on the 8th, done once.
- DW 5x4 with src_valid alternating 1/0 -> same 6 win_valid, each still exactly 2 cycles after its accepted beat. No tag on idle cycles.
- DW width=2, height=4 -> no CFG and no src_ready. done and cfg_err pulse together 1 cycle after start, busy high 1 cycle. Also PW width=0 -> same.
- start pulsed again mid-RUN -> ignored; counts and pp_* unchanged. The next start after done begins a new layer with new config.
- rstn low for 1 cycle mid-RUN (row 2) -> all outputs 0 immediately. No done, no further win_valid. A subsequent start runs a full clean layer.
